// File: rtl/ecc_pkg.sv
// Shared constants and state encoding for the ECDSA prime-field datapath.
// Field size, the secp256k1 prime, and the multiplier FSM states.
package ecc_pkg;

    localparam int N_BITS = 256;

    localparam logic [N_BITS-1:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mm_state_e;

endpackage

// File: rtl/modular_multiplier_if.sv
// Operand/result bundle of the bit-serial modular multiplier.
// The master drives the operands; the slave returns the result and its done flag.
interface modular_multiplier_if #(
    parameter int n = 256
);
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic [n-1:0] p;
    logic [n-1:0] M;
    logic         flag;

    modport master (output A, output B, output p, input M, input flag);
    modport slave  (input A, input B, input p, output M, output flag);
endinterface

// File: rtl/modular_multiplier_mod_dbl_add.sv
// One Blakley step: ((2r mod p) + b_bit*a) mod p, assuming r < p and a < p.
// Both stages are (n+1) bits wide so the doubling and the addition cannot overflow.
module mod_dbl_add #(
    parameter int n = 256
) (
    input  logic [n-1:0] r,
    input  logic [n-1:0] a,
    input  logic [n-1:0] p,
    input  logic         b_bit,
    output logic [n-1:0] res
);

    logic [n:0] p_x;
    logic [n:0] dbl;
    logic [n:0] dbl_red;
    logic [n:0] sum;

    always_comb begin
        p_x     = {1'b0, p};
        dbl     = {r, 1'b0};
        dbl_red = (dbl >= p_x) ? (dbl - p_x) : dbl;
        sum     = b_bit ? (dbl_red + {1'b0, a}) : dbl_red;
        // After one conditional subtract the value is below p, so the top bit is zero.
        res     = (sum >= p_x) ? n'(sum - p_x) : n'(sum);
    end

endmodule

// File: rtl/modular_multiplier.sv
// Bit-serial interleaved (Blakley) modular multiplier: M = (A*B) mod p.
// Scans B MSB-first, one bit per clock, then holds the result until the operands change.
module modular_multiplier
    import ecc_pkg::*;
#(
    parameter int n = N_BITS
) (
    input  logic                clk,
    input  logic                reset,
    modular_multiplier_if.slave bus
);

    localparam int CNT_W = $clog2(n);

    mm_state_e        state;
    mm_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [n-1:0]     a_l;
    logic [n-1:0]     b_l;
    logic [n-1:0]     p_l;
    logic [n-1:0]     r;
    logic [n-1:0]     r_nxt;
    logic [n-1:0]     m_q;
    logic             flag_q;
    logic             changed;

    assign changed  = (bus.A != a_l) || (bus.B != b_l) || (bus.p != p_l);
    assign bus.M    = m_q;
    assign bus.flag = flag_q;

    mod_dbl_add #(.n(n)) u_step (
        .r     (r),
        .a     (a_l),
        .p     (p_l),
        .b_bit (b_l[cnt]),
        .res   (r_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = DONE;
            // A restart is only considered once the current result has been published.
            DONE:    if (flag_q && changed) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Operand copies only matter after LOAD has captured them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            a_l <= bus.A;
            b_l <= bus.B;
            p_l <= bus.p;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r      <= '0;
            cnt    <= CNT_W'(n - 1);
            m_q    <= '0;
            flag_q <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    r   <= '0;
                    cnt <= CNT_W'(n - 1);
                end
                RUN: begin
                    r <= r_nxt;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                DONE: begin
                    if (!flag_q) begin
                        m_q    <= r;
                        flag_q <= 1'b1;
                    end else if (changed) begin
                        flag_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modular_multiplier.sv
// Directed and random checks of the secp256k1 field multiplier against a big-integer model.
module tb_modular_multiplier;
    import ecc_pkg::*;

    localparam int N = N_BITS;
    localparam logic [N-1:0] P = SECP256K1_P;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    modular_multiplier_if #(.n(N)) mif ();

    modular_multiplier #(.n(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] last_exp;
    logic [N-1:0] a;
    logic [N-1:0] b;

    function automatic logic [N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] prod;
        logic [2*N-1:0] rem;
        prod = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        rem  = prod % {{N{1'b0}}, P};
        return rem[N-1:0];
    endfunction

    function automatic logic [N-1:0] rand_word();
        logic [N-1:0] w;
        for (int i = 0; i < N / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Counts rising edges until flag appears; flag must stay low for the whole run.
    task automatic wait_flag(input string tag);
        int cnt = 0;
        bit seen = 1'b0;
        while (!seen && cnt < 400) begin
            @(posedge clk);
            cnt++;
            #1;
            seen = (mif.flag === 1'b1);
        end
        check({tag, " latency"}, N'(cnt), N'(N + 2));
        last_exp = exp_q.pop_front();
        check({tag, " M"}, mif.M, last_exp);
    endtask

    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y,
                          input logic [N-1:0] exp, input string tag);
        @(negedge clk);
        reset = 1'b0;
        mif.A = x;
        mif.B = y;
        mif.p = P;
        exp_q.push_back(exp);
        @(negedge clk);
        reset = 1'b1;
        wait_flag(tag);
    endtask

    task automatic change_op(input logic [N-1:0] x, input logic [N-1:0] y,
                             input logic [N-1:0] exp, input string tag);
        @(negedge clk);
        mif.A = x;
        mif.B = y;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check({tag, " flag drop"}, N'(mif.flag), N'(0));
        wait_flag(tag);
    endtask

    task automatic hold_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check({tag, " flag hold"}, N'(mif.flag), N'(1));
            check({tag, " M hold"}, mif.M, last_exp);
        end
    endtask

    initial begin
        mif.A = '0;
        mif.B = '0;
        mif.p = P;
        #12;
        check("reset M", mif.M, '0);
        check("reset flag", N'(mif.flag), N'(0));

        run_op(N'(3), N'(5), N'(15), "t1 3*5");

        run_op(P - N'(1), P - N'(1), N'(1), "t2 (p-1)^2");
        run_op(P - N'(1), N'(2), P - N'(2), "t2 (p-1)*2");

        b = rand_word();
        run_op('0, b, '0, "t3 A=0");
        a = rand_word() % P;
        run_op(a, '0, '0, "t3 B=0");
        a = rand_word() % P;
        run_op(a, N'(1), a, "t3 B=1");

        a = N'(192'hf3eaf3b95d6d94260bb91af829600303535b2b331893bd3d);
        b = N'(192'h3731fecb6367c15e7503c0ce01380c628aa5fe01fe31c9f3);
        run_op(a, b, ref_mul(a, b), "t4 vector");

        for (int k = 0; k < 24; k++) begin
            a = rand_word() % P;
            b = rand_word();
            run_op(a, b, ref_mul(a, b), "t4 random");
        end

        hold_check(20, "t6 hold");

        b = rand_word();
        change_op(a, b, ref_mul(a, b), "t6 change B");
        hold_check(10, "t6 hold after restart");

        // Restart with a new B, then abort mid-run while M still holds the previous result.
        b = rand_word();
        @(negedge clk);
        mif.B = b;
        repeat (100) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5 async reset M", mif.M, '0);
        check("t5 async reset flag", N'(mif.flag), N'(0));
        run_op(a, b, ref_mul(a, b), "t5 rerun");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
